// File: rtl/io_reg_pkg.sv
// Shared types and constants for the OQI output staging block.
package io_reg_pkg;

   localparam int OQI_W = 18;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } oqi_state_t;

   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/io_oqi_fifo.sv
// Staging FIFO for io_oqi_stage: storage array, wrapping pointers and an explicit occupancy counter.
module io_oqi_fifo
   import io_reg_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic             IQC,
   input  logic             QRT,
   input  logic             i_push,
   input  logic [0:OQI_W-1] i_wdata,
   input  logic             i_pop,
   output logic [0:OQI_W-1] o_head,
   output logic [4:0]       o_cnt,
   output logic             o_full
);

   localparam int         PW      = ptr_w(DEPTH);
   localparam logic [4:0] DEPTH_C = 5'(DEPTH);

   logic [0:OQI_W-1] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [4:0]       r_cnt;

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge IQC) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 5'd1;
            2'b01:   r_cnt <= r_cnt - 5'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head = r_mem[r_rd_ptr];
   assign o_cnt  = r_cnt;
   assign o_full = (r_cnt == DEPTH_C);

endmodule

// File: rtl/io_oqi_stage.sv
// OQI output stage: FIFO-buffered words presented on OQI for at least MIN_HOLD cycles per word.
// Optional parity output oqi_par is enabled by defining IO_OQI_PARITY_EN.
module io_oqi_stage
   import io_reg_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MIN_HOLD = 1
)
(
   input  logic             IQC,
   input  logic             QRT,
   input  logic [0:OQI_W-1] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [0:OQI_W-1] OQI,
   output logic             oqi_valid,
   input  logic             oqi_ack,
   output logic [4:0]       fifo_cnt,
   output logic             ovf
`ifdef IO_OQI_PARITY_EN
  ,output logic             oqi_par
`endif
);

   localparam logic [3:0] HOLD_MAX = 4'(MIN_HOLD);

   oqi_state_t       r_state;
   oqi_state_t       w_state_next;
   logic [3:0]       r_hcnt;
   logic [3:0]       w_hcnt_next;
   logic [0:OQI_W-1] r_oqi;
   logic [0:OQI_W-1] w_head;
   logic             r_valid;
   logic             r_ovf;
   logic             w_valid_next;
   logic             w_push;
   logic             w_pop;
   logic             w_ack_ok;
   logic             w_full;
   logic             w_has_data;
   logic [4:0]       w_cnt;

   // Ready depends only on the registered count, never on oqi_ack.
   assign in_ready   = ~w_full;
   assign w_push     = in_valid & ~w_full;
   assign w_has_data = (w_cnt != 5'd0);
   assign w_ack_ok   = oqi_ack & (r_hcnt >= HOLD_MAX);

   io_oqi_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .IQC     (IQC),
      .QRT     (QRT),
      .i_push  (w_push),
      .i_wdata (in_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_cnt   (w_cnt),
      .o_full  (w_full)
   );

   always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         EMPTY:   if (w_has_data) w_state_next = HOLD;
         HOLD:    if (w_ack_ok && !w_has_data) w_state_next = EMPTY;
         default: w_state_next = EMPTY;
      endcase
   end

   always_comb begin
      w_pop        = 1'b0;
      w_valid_next = r_valid;
      w_hcnt_next  = r_hcnt;
      case (r_state)
         EMPTY: begin
            if (w_has_data) begin
               w_pop        = 1'b1;
               w_valid_next = 1'b1;
               w_hcnt_next  = 4'd1;
            end
         end
         HOLD: begin
            // An early ack is simply dropped; nothing remembers it.
            if (w_ack_ok) begin
               if (w_has_data) begin
                  w_pop       = 1'b1;
                  w_hcnt_next = 4'd1;
               end else begin
                  w_valid_next = 1'b0;
                  w_hcnt_next  = 4'd0;
               end
            end else if (r_hcnt < HOLD_MAX) begin
               w_hcnt_next = r_hcnt + 4'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
         r_oqi   <= '0;
         r_valid <= 1'b0;
         r_hcnt  <= 4'd0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_pop) begin
            r_oqi <= w_head;
         end
         r_valid <= w_valid_next;
         r_hcnt  <= w_hcnt_next;
         if (in_valid && w_full) begin
            r_ovf <= 1'b1;
         end
      end
   end

`ifdef IO_OQI_PARITY_EN
   logic r_par;

   always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
         r_par <= 1'b0;
      end else if (w_pop) begin
         r_par <= ^w_head;
      end
   end

   assign oqi_par = r_par;
`endif

   assign OQI       = r_oqi;
   assign oqi_valid = r_valid;
   assign fifo_cnt  = w_cnt;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_io_oqi_stage.sv
// Bench for io_oqi_stage: two instances (MIN_HOLD=1 and MIN_HOLD=3) share one stimulus stream
// and are checked every cycle against a queue-level model plus directed literal expectations.
module tb_io_oqi_stage;

   localparam int DEPTH = 4;
   localparam int NI    = 2;

   logic        IQC      = 1'b0;
   logic        QRT      = 1'b0;
   logic [0:17] in_data  = '0;
   logic        in_valid = 1'b0;
   logic        oqi_ack  = 1'b0;

   logic        d_ready [NI];
   logic        d_valid [NI];
   logic        d_ovf   [NI];
   logic [0:17] d_oqi   [NI];
   logic [4:0]  d_cnt   [NI];
`ifdef IO_OQI_PARITY_EN
   logic        d_par   [NI];
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 IQC = ~IQC;

   io_oqi_stage #(.DEPTH(DEPTH), .MIN_HOLD(1)) u_dut_h1 (
      .IQC       (IQC),
      .QRT       (QRT),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (d_ready[0]),
      .OQI       (d_oqi[0]),
      .oqi_valid (d_valid[0]),
      .oqi_ack   (oqi_ack),
      .fifo_cnt  (d_cnt[0]),
      .ovf       (d_ovf[0])
`ifdef IO_OQI_PARITY_EN
     ,.oqi_par   (d_par[0])
`endif
   );

   io_oqi_stage #(.DEPTH(DEPTH), .MIN_HOLD(3)) u_dut_h3 (
      .IQC       (IQC),
      .QRT       (QRT),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (d_ready[1]),
      .OQI       (d_oqi[1]),
      .oqi_valid (d_valid[1]),
      .oqi_ack   (oqi_ack),
      .fifo_cnt  (d_cnt[1]),
      .ovf       (d_ovf[1])
`ifdef IO_OQI_PARITY_EN
     ,.oqi_par   (d_par[1])
`endif
   );

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s u%0d at %0t: got %0h expected %0h", nm, k, $time, act, exp);
      end
   endtask

   // Model: a queue of waiting words plus the presented word and how long it has been shown.
   int          m_mh [NI] = '{1, 3};
   logic [17:0] m_buf [NI][DEPTH];
   int          m_head [NI];
   int          m_n    [NI];
   int          m_age  [NI];
   logic        m_valid [NI];
   logic        m_ovf   [NI];
   logic [17:0] m_oqi   [NI];

   always @(posedge IQC or negedge QRT) begin
      bit accept;
      for (int k = 0; k < NI; k++) begin
         if (!QRT) begin
            m_head[k]  = 0;
            m_n[k]     = 0;
            m_age[k]   = 0;
            m_valid[k] = 1'b0;
            m_ovf[k]   = 1'b0;
            m_oqi[k]   = '0;
         end else begin
            accept = in_valid && (m_n[k] != DEPTH);
            if (in_valid && !accept) m_ovf[k] = 1'b1;
            if (!m_valid[k] || (oqi_ack && m_age[k] >= m_mh[k])) begin
               if (m_n[k] > 0) begin
                  m_oqi[k]   = m_buf[k][m_head[k]];
                  m_head[k]  = (m_head[k] + 1) % DEPTH;
                  m_n[k]     = m_n[k] - 1;
                  m_valid[k] = 1'b1;
                  m_age[k]   = 1;
               end else begin
                  m_valid[k] = 1'b0;
               end
            end else if (m_age[k] < m_mh[k]) begin
               m_age[k] = m_age[k] + 1;
            end
            if (accept) begin
               m_buf[k][(m_head[k] + m_n[k]) % DEPTH] = in_data;
               m_n[k] = m_n[k] + 1;
            end
         end
      end
   end

   always @(negedge IQC) begin
      for (int k = 0; k < NI; k++) begin
         chk("in_ready",  k, 32'(d_ready[k]), 32'(m_n[k] != DEPTH));
         chk("oqi_valid", k, 32'(d_valid[k]), 32'(m_valid[k]));
         chk("fifo_cnt",  k, 32'(d_cnt[k]),   32'(m_n[k]));
         chk("ovf",       k, 32'(d_ovf[k]),   32'(m_ovf[k]));
         chk("OQI",       k, 32'(d_oqi[k]),   32'(m_oqi[k]));
`ifdef IO_OQI_PARITY_EN
         chk("oqi_par",   k, 32'(d_par[k]),   32'(^m_oqi[k]));
`endif
      end
   end

   task automatic tick();
      @(posedge IQC);
      #2;
   endtask

   task automatic chk_reset_values(input string tag);
      for (int k = 0; k < NI; k++) begin
         chk({tag, "_in_ready"}, k, 32'(d_ready[k]), 32'd1);
         chk({tag, "_valid"},    k, 32'(d_valid[k]), 32'd0);
         chk({tag, "_cnt"},      k, 32'(d_cnt[k]),   32'd0);
         chk({tag, "_ovf"},      k, 32'(d_ovf[k]),   32'd0);
         chk({tag, "_oqi"},      k, 32'(d_oqi[k]),   32'd0);
`ifdef IO_OQI_PARITY_EN
         chk({tag, "_par"},      k, 32'(d_par[k]),   32'd0);
`endif
      end
   endtask

   initial begin
      repeat (2) tick();
      chk_reset_values("rst");
      QRT = 1'b1;

      // Single word with ack held: visible two edges after push, dropped the edge after the ack.
      oqi_ack  = 1'b1;
      in_data  = 18'h2AAAA;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("s1_valid_e1", 0, 32'(d_valid[0]), 32'd0);
      chk("s1_cnt_e1",   0, 32'(d_cnt[0]),   32'd1);
      tick();
      chk("s1_valid_e2", 0, 32'(d_valid[0]), 32'd1);
      chk("s1_oqi_e2",   0, 32'(d_oqi[0]),   32'h2AAAA);
      tick();
      chk("s1_valid_e3", 0, 32'(d_valid[0]), 32'd0);
      chk("s1_oqi_e3",   0, 32'(d_oqi[0]),   32'h2AAAA);
      repeat (4) tick();
      chk("s1_h3_drained", 1, 32'(d_valid[1]), 32'd0);
      oqi_ack = 1'b0;

      // Fill with no ack: five accepted, sixth overflows.
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 18'(18'h10001 + i);
         tick();
         if (i == 4) begin
            for (int k = 0; k < NI; k++) begin
               chk("s2_ready_full", k, 32'(d_ready[k]), 32'd0);
               chk("s2_cnt_full",   k, 32'(d_cnt[k]),   32'd4);
               chk("s2_ovf_before", k, 32'(d_ovf[k]),   32'd0);
            end
         end
      end
      for (int k = 0; k < NI; k++) begin
         chk("s2_ovf",  k, 32'(d_ovf[k]), 32'd1);
         chk("s2_cnt",  k, 32'(d_cnt[k]), 32'd4);
         chk("s2_oqi",  k, 32'(d_oqi[k]), 32'h10001);
      end

      // Full FIFO, honoured ack and rejected push on the same edge.
      oqi_ack  = 1'b1;
      in_data  = 18'h3FFFF;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < NI; k++) begin
         chk("s4_cnt",   k, 32'(d_cnt[k]),   32'd3);
         chk("s4_ready", k, 32'(d_ready[k]), 32'd1);
         chk("s4_oqi",   k, 32'(d_oqi[k]),   32'h10002);
      end

      // MIN_HOLD=3 with ack held: one new word every third edge, in push order.
      for (int j = 1; j < 12; j++) begin
         tick();
         chk("s3_oqi",   1, 32'(d_oqi[1]),   32'(32'h10002 + j / 3));
         chk("s3_valid", 1, 32'(d_valid[1]), 32'd1);
      end
      tick();
      chk("s3_valid_end", 1, 32'(d_valid[1]), 32'd0);
      chk("s3_oqi_end",   1, 32'(d_oqi[1]),   32'h10005);
      oqi_ack = 1'b0;

      // Reset pulsed mid-HOLD with two words still queued.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 18'(18'h20001 + i);
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < NI; k++) begin
         chk("s5_cnt_pre", k, 32'(d_cnt[k]), 32'd2);
         chk("s5_oqi_pre", k, 32'(d_oqi[k]), 32'h20001);
      end
      QRT = 1'b0;
      #1;
      chk_reset_values("async");
      tick();
      QRT = 1'b1;

      // First edge after release accepts a push; parity words follow.
      in_valid = 1'b1;
      in_data  = 18'h00007;
      tick();
      chk("s5_cnt_post",   0, 32'(d_cnt[0]),   32'd1);
      chk("s5_valid_post", 0, 32'(d_valid[0]), 32'd0);
      in_data = 18'h00003;
      oqi_ack = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("s6_oqi7", 0, 32'(d_oqi[0]), 32'h00007);
`ifdef IO_OQI_PARITY_EN
      chk("s6_par7", 0, 32'(d_par[0]), 32'd1);
`endif
      tick();
      chk("s6_oqi3", 0, 32'(d_oqi[0]), 32'h00003);
`ifdef IO_OQI_PARITY_EN
      chk("s6_par3", 0, 32'(d_par[0]), 32'd0);
`endif
      repeat (8) tick();
      oqi_ack = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
